// File: rtl/ctrl_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_pipe
//
// Control-payload pipeline that sits behind the decode stage of an ARM-style
// core. Stage 1 is Execute, where the condition code is evaluated against the
// architectural flags. Stage NSTAGES is Writeback, where executed
// instructions are counted as retired.
//
// Ports
//   clk             clock, every state update happens on its rising edge
//   reset           synchronous, active-low
//   d_valid         a decode-stage instruction is present
//   d_ctrl          decode-stage control payload
//   d_cond          decode-stage condition code
//   d_flagwrite     [1] writes N,Z; [0] writes C,V and ORs into sticky Q
//   d_branch        the decode-stage instruction is a branch
//   alu_flags_e     ALU flags {N,Z,C,V,Q} of the stage-1 instruction
//   stall_i         per-stage hold, bit k-1 controls stage k
//   flush_i         per-stage clear, bit k-1 controls stage k
//   stage_valid     valid bit of each stage register
//   stage_ctrl      payload of each stage, stage k at [(k-1)*CTRL_WIDTH +: CTRL_WIDTH]
//   condex_e        the stage-1 condition passes
//   branch_taken_e  the stage-1 branch is taken
//   flags_q         architectural flags register
//   pc_wr_pending   a PC write is somewhere between decode and writeback
//   retired_count   executed instructions that have left the last stage
// ---------------------------------------------------------------------------
module ctrl_pipe #(
  parameter int                    CTRL_WIDTH  = 8,
  parameter int                    NSTAGES     = 3,
  parameter int                    FLAGS_WIDTH = 5,
  parameter logic [CTRL_WIDTH-1:0] GATE_MASK   = 8'b0001_1110,
  parameter int                    PCSRC_BIT   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          d_valid,
  input  logic [CTRL_WIDTH-1:0]         d_ctrl,
  input  logic [3:0]                    d_cond,
  input  logic [1:0]                    d_flagwrite,
  input  logic                          d_branch,
  input  logic [FLAGS_WIDTH-1:0]        alu_flags_e,
  input  logic [NSTAGES-1:0]            stall_i,
  input  logic [NSTAGES-1:0]            flush_i,
  output logic [NSTAGES-1:0]            stage_valid,
  output logic [NSTAGES*CTRL_WIDTH-1:0] stage_ctrl,
  output logic                          condex_e,
  output logic                          branch_taken_e,
  output logic [FLAGS_WIDTH-1:0]        flags_q,
  output logic                          pc_wr_pending,
  output logic [31:0]                   retired_count
);

  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Q = 0;

  // Index 0 is stage 1 (Execute). Only stage 1 needs the condition,
  // flag-write and branch fields; later stages carry the gated payload plus
  // an executed bit that says whether the condition passed.
  logic                  stageValidQ [NSTAGES];
  logic [CTRL_WIDTH-1:0] stageCtrlQ  [NSTAGES];
  logic                  stageExecQ  [NSTAGES];
  logic [3:0]            condQ;
  logic [1:0]            flagWriteQ;
  logic                  branchQ;
  logic [FLAGS_WIDTH-1:0] flagsQ;
  logic [31:0]           retiredQ;

  logic                  condPass;
  logic [CTRL_WIDTH-1:0] gatedCtrl;
  logic                  pcWrPending;

  // ARM condition decode against the current (pre-update) flags. Stage 1
  // sees the flags as they stand before its own write lands; there is no
  // forwarding, so back-to-back flag producer/consumer pairs must be spaced
  // by the decoder. Cond 4'b1111 (NV) never passes.
  always_comb begin
    condPass = 1'b0;
    case (condQ)
      4'h0: condPass = flagsQ[FLAG_Z];
      4'h1: condPass = ~flagsQ[FLAG_Z];
      4'h2: condPass = flagsQ[FLAG_C];
      4'h3: condPass = ~flagsQ[FLAG_C];
      4'h4: condPass = flagsQ[FLAG_N];
      4'h5: condPass = ~flagsQ[FLAG_N];
      4'h6: condPass = flagsQ[FLAG_V];
      4'h7: condPass = ~flagsQ[FLAG_V];
      4'h8: condPass = flagsQ[FLAG_C] & ~flagsQ[FLAG_Z];
      4'h9: condPass = ~flagsQ[FLAG_C] | flagsQ[FLAG_Z];
      4'hA: condPass = (flagsQ[FLAG_N] == flagsQ[FLAG_V]);
      4'hB: condPass = (flagsQ[FLAG_N] != flagsQ[FLAG_V]);
      4'hC: condPass = ~flagsQ[FLAG_Z] & (flagsQ[FLAG_N] == flagsQ[FLAG_V]);
      4'hD: condPass = flagsQ[FLAG_Z] | (flagsQ[FLAG_N] != flagsQ[FLAG_V]);
      4'hE: condPass = 1'b1;
      default: condPass = 1'b0;
    endcase
  end

  assign condex_e       = stageValidQ[0] & condPass;
  assign branch_taken_e = stageValidQ[0] & branchQ & condex_e;

  // A failed condition strips the side-effect bits from the payload but
  // keeps the slot valid, so downstream still sees an occupied stage.
  assign gatedCtrl = condex_e ? stageCtrlQ[0] : (stageCtrlQ[0] & ~GATE_MASK);

  // Pipeline registers, flags and retirement counter. Priority per stage is
  // reset, then flush, then stall (hold), then bubble-or-advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NSTAGES; k++) begin
        stageValidQ[k] <= 1'b0;
        stageCtrlQ[k]  <= '0;
        stageExecQ[k]  <= 1'b0;
      end
      condQ      <= '0;
      flagWriteQ <= '0;
      branchQ    <= 1'b0;
      flagsQ     <= '0;
      retiredQ   <= '0;
    end else begin
      if (flush_i[0]) begin
        stageValidQ[0] <= 1'b0;
        stageCtrlQ[0]  <= '0;
        condQ          <= '0;
        flagWriteQ     <= '0;
        branchQ        <= 1'b0;
      end else if (!stall_i[0]) begin
        stageValidQ[0] <= d_valid;
        stageCtrlQ[0]  <= d_ctrl;
        condQ          <= d_cond;
        flagWriteQ     <= d_flagwrite;
        branchQ        <= d_branch;
      end

      for (int k = 1; k < NSTAGES; k++) begin
        if (flush_i[k]) begin
          stageValidQ[k] <= 1'b0;
          stageCtrlQ[k]  <= '0;
          stageExecQ[k]  <= 1'b0;
        end else if (!stall_i[k]) begin
          if (stall_i[k-1]) begin
            stageValidQ[k] <= 1'b0;
            stageCtrlQ[k]  <= '0;
            stageExecQ[k]  <= 1'b0;
          end else if (k == 1) begin
            stageValidQ[k] <= stageValidQ[0];
            stageCtrlQ[k]  <= gatedCtrl;
            stageExecQ[k]  <= condex_e;
          end else begin
            stageValidQ[k] <= stageValidQ[k-1];
            stageCtrlQ[k]  <= stageCtrlQ[k-1];
            stageExecQ[k]  <= stageExecQ[k-1];
          end
        end
      end

      if (condex_e && !stall_i[0]) begin
        if (flagWriteQ[1]) begin
          flagsQ[FLAG_N] <= alu_flags_e[FLAG_N];
          flagsQ[FLAG_Z] <= alu_flags_e[FLAG_Z];
        end
        if (flagWriteQ[0]) begin
          flagsQ[FLAG_C] <= alu_flags_e[FLAG_C];
          flagsQ[FLAG_V] <= alu_flags_e[FLAG_V];
          flagsQ[FLAG_Q] <= flagsQ[FLAG_Q] | alu_flags_e[FLAG_Q];
        end
      end

      if (stageValidQ[NSTAGES-1] && stageExecQ[NSTAGES-1] && !stall_i[NSTAGES-1]) begin
        retiredQ <= retiredQ + 32'd1;
      end
    end
  end

  // Flatten the stage registers onto the output buses.
  always_comb begin
    stage_valid = '0;
    stage_ctrl  = '0;
    for (int k = 0; k < NSTAGES; k++) begin
      stage_valid[k]                             = stageValidQ[k];
      stage_ctrl[k*CTRL_WIDTH +: CTRL_WIDTH]     = stageCtrlQ[k];
    end
  end

  // A PC write is pending if decode or any occupied stage carries the PC
  // source bit. Stages 2 and up already hold the gated payload, so a
  // condition-failed PC write drops out once it leaves Execute.
  always_comb begin
    pcWrPending = d_valid & d_ctrl[PCSRC_BIT];
    for (int k = 0; k < NSTAGES; k++) begin
      pcWrPending = pcWrPending | (stageValidQ[k] & stageCtrlQ[k][PCSRC_BIT]);
    end
  end

  assign pc_wr_pending = pcWrPending;
  assign flags_q       = flagsQ;
  assign retired_count = retiredQ;

endmodule
